// File: rtl/mapping_group_readout.sv
// mapping_group_readout
// Read-out sequencer for the output-buffer mapping groups. A core-side load
// request names a starting group and either a single word or a burst up to
// the last group. For every word exactly one group's load enable is pulsed
// and that group's combinational output is captured the same cycle into a
// small response FIFO, which is drained through a valid/ready handshake.
//
// Ports:
//   clk_i, rst_ni          clock (rising edge), asynchronous active-low reset
//   req_valid_i/ready_o    load request handshake
//   req_group_i            first group index
//   req_burst_i            0: single word, 1: req_group_i..NUM_GROUPS-1
//   load_en_o              one-hot-or-zero load enable per group
//   mapping_group_i        group g output at bits [32g+31:32g]
//   rsp_valid_o/ready_i    response handshake
//   rsp_data_o             response word
//   rsp_last_o             final word of the request
//   rsp_err_o              request carried an out-of-range group index
//   busy_o                 loading or response words still queued
module mapping_group_readout #(
  parameter int NUM_GROUPS = 4,
  parameter int FIFO_DEPTH = 2,
  parameter int GW         = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic [GW-1:0]            req_group_i,
  input  logic                     req_burst_i,
  output logic [NUM_GROUPS-1:0]    load_en_o,
  input  logic [NUM_GROUPS*32-1:0] mapping_group_i,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic [31:0]              rsp_data_o,
  output logic                     rsp_last_o,
  output logic                     rsp_err_o,
  output logic                     busy_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [GW-1:0] LAST_G  = GW'(NUM_GROUPS - 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [PW-1:0] PTR_MAX = PW'(FIFO_DEPTH - 1);

  typedef enum logic {S_IDLE, S_LOAD} state_e;

  state_e        state_q, state_d;
  logic [GW-1:0] cur_q, cur_d;
  logic [GW-1:0] end_q, end_d;
  logic          err_pend_q, err_pend_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // Entry layout: {data[31:0], err, last}
  logic [33:0]   mem_q [FIFO_DEPTH];
  logic [33:0]   wr_entry;
  logic [33:0]   head;

  logic          push, pop, space, req_fire, grp_ok;
  logic [31:0]   grp_ext;
  logic [31:0]   cur_word;

  // A pop in the same cycle does not count as free space: the load enable
  // must only fire when the captured word is guaranteed a slot.
  assign space       = (count_q < DEPTH_C);
  assign grp_ext     = 32'(req_group_i);
  assign grp_ok      = (grp_ext < 32'(NUM_GROUPS));
  assign req_ready_o = (state_q == S_IDLE) && !err_pend_q;
  assign req_fire    = req_valid_i && req_ready_o;
  assign cur_word    = mapping_group_i[32*cur_q +: 32];

  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    end_d      = end_q;
    err_pend_d = err_pend_q;
    push       = 1'b0;
    wr_entry   = '0;
    load_en_o  = '0;
    case (state_q)
      S_IDLE: begin
        if (err_pend_q) begin
          // Error response waiting for a FIFO slot; requests are held off.
          if (space) begin
            push       = 1'b1;
            wr_entry   = {32'd0, 1'b1, 1'b1};
            err_pend_d = 1'b0;
          end
        end else if (req_fire) begin
          if (grp_ok) begin
            cur_d   = req_group_i;
            end_d   = req_burst_i ? LAST_G : req_group_i;
            state_d = S_LOAD;
          end else if (space) begin
            push     = 1'b1;
            wr_entry = {32'd0, 1'b1, 1'b1};
          end else begin
            err_pend_d = 1'b1;
          end
        end
      end
      S_LOAD: begin
        // Stall with load_en low when full: a group read may have side
        // effects, so each group is pulsed exactly once per word.
        if (space) begin
          load_en_o[cur_q] = 1'b1;
          push             = 1'b1;
          wr_entry         = {cur_word, 1'b0, (cur_q == end_q)};
          cur_d            = cur_q + 1'b1;
          if (cur_q == end_q) begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign pop = (count_q != '0) && rsp_ready_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == PTR_MAX) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_MAX) ? '0 : rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      cur_q      <= '0;
      end_q      <= '0;
      err_pend_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      end_q      <= end_d;
      err_pend_q <= err_pend_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Storage carries no reset; outputs are gated by the occupancy count.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_entry;
    end
  end

  assign head        = mem_q[rd_ptr_q];
  assign rsp_valid_o = (count_q != '0);
  assign rsp_data_o  = rsp_valid_o ? head[33:2] : 32'd0;
  assign rsp_err_o   = rsp_valid_o & head[1];
  assign rsp_last_o  = rsp_valid_o & head[0];
  assign busy_o      = (state_q == S_LOAD) || (count_q != '0);

endmodule
